// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC transaction scheduler.
//   state_e   : scheduler FSM states
//   op_e      : kind of operation in flight (three write requesters + read sweep)
//   ADDR_*    : first RTC register address of each 3-byte group
//   SWEEP_LEN : number of reads per automatic sweep
// Build option: define RTC_CRONO_EN to include the chronometer group
// (0x41..0x43) in the sweep and enable the chronometer write requester.
package rtc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT
  } state_e;

  typedef enum logic [1:0] {
    OP_HORA,
    OP_FECHA,
    OP_CRONO,
    OP_READ
  } op_e;

  localparam logic [7:0] ADDR_HORA  = 8'h21;
  localparam logic [7:0] ADDR_FECHA = 8'h24;
  localparam logic [7:0] ADDR_CRONO = 8'h41;

  // Bytes per write burst, and reads covering the time+date groups.
  localparam int unsigned WRITE_LEN = 3;
  localparam int unsigned HF_LEN    = 6;

`ifdef RTC_CRONO_EN
  localparam int unsigned SWEEP_LEN = 9;
`else
  localparam int unsigned SWEEP_LEN = 6;
`endif

endpackage

// File: rtl/rtc_addr_rom.sv
// Address / write-byte selection for the RTC scheduler.
// Ports:
//   op_i   : operation kind
//   idx_i  : byte index within a write burst (0..2) or sweep index (0..8)
//   data_i : captured 24-bit BCD data {byte2,byte1,byte0}
//   addr_o : RTC register address for this step
//   data_o : write byte for this step (byte idx_i of data_i)
module rtc_addr_rom
  import rtc_pkg::*;
(
  input  op_e         op_i,
  input  logic [3:0]  idx_i,
  input  logic [23:0] data_i,
  output logic [7:0]  addr_o,
  output logic [7:0]  data_o
);

  always_comb begin
    addr_o = '0;
    case (op_i)
      OP_HORA:  addr_o = ADDR_HORA  + {6'd0, idx_i[1:0]};
      OP_FECHA: addr_o = ADDR_FECHA + {6'd0, idx_i[1:0]};
      OP_CRONO: addr_o = ADDR_CRONO + {6'd0, idx_i[1:0]};
      // Sweep: time+date registers are contiguous, chronometer group follows.
      OP_READ:  addr_o = (idx_i < 4'(HF_LEN)) ? ADDR_HORA + {4'd0, idx_i}
                                              : ADDR_CRONO + {4'd0, 4'(idx_i - 4'(HF_LEN))};
      default:  addr_o = '0;
    endcase
  end

  always_comb begin
    data_o = '0;
    case (idx_i[1:0])
      2'd0:    data_o = data_i[7:0];
      2'd1:    data_o = data_i[15:8];
      2'd2:    data_o = data_i[23:16];
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/rtc_scheduler.sv
// RTC transaction scheduler: arbitrates time/date/chronometer write requests
// and a periodic read sweep, issuing one register transaction at a time to
// the RTC protocol engine (inicio -> ... -> fin handshake).
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   camb_hora/camb_fecha/camb_crono    : write-request pulses
//   hora_in/fecha_in/crono_in          : 24-bit BCD data, sampled at grant
//   fin                                : transaction-done pulse from engine
//   inicio                             : one-cycle transaction start
//   IndicadorMaquina                   : 1 = write, 0 = read
//   address, DATA_WRITE                : register address / write byte
//   contador2, captura                 : sweep index / read-byte-valid pulse
//   ocupado, err_timeout               : busy / sticky timeout flag
// Build option: RTC_CRONO_EN enables the chronometer requester and extends
// the sweep to 0x41..0x43; without it camb_crono and crono_in are ignored.
module rtc_scheduler
  import rtc_pkg::*;
#(
  parameter int unsigned REFRESH_CYCLES = 100000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        camb_hora,
  input  logic        camb_fecha,
  input  logic        camb_crono,
  input  logic [23:0] hora_in,
  input  logic [23:0] fecha_in,
  input  logic [23:0] crono_in,
  input  logic        fin,
  output logic        inicio,
  output logic        IndicadorMaquina,
  output logic [7:0]  address,
  output logic [7:0]  DATA_WRITE,
  output logic [3:0]  contador2,
  output logic        captura,
  output logic        ocupado,
  output logic        err_timeout
);

  localparam int unsigned RW = $clog2(REFRESH_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [3:0]    idx_q, idx_d;
  logic [23:0]   data_q, data_d;
  logic          pend_hora_q, pend_hora_d;
  logic          pend_fecha_q, pend_fecha_d;
  logic          pend_crono_q, pend_crono_d;
  logic          sweep_due_q, sweep_due_d;
  logic [RW-1:0] idle_cnt_q, idle_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          cap_q, cap_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    dw_q, dw_d;
  logic          wr_q, wr_d;
  logic [3:0]    cnt2_q, cnt2_d;
  logic [3:0]    last_idx;
  logic [7:0]    rom_addr, rom_data;
  logic          crono_req;
  logic [23:0]   crono_data;

`ifdef RTC_CRONO_EN
  assign crono_req  = camb_crono;
  assign crono_data = crono_in;
`else
  logic unused_crono;
  assign crono_req    = 1'b0;
  assign crono_data   = '0;
  assign unused_crono = ^{camb_crono, crono_in};
`endif

  assign last_idx = (op_q == OP_READ) ? 4'(SWEEP_LEN - 1) : 4'(WRITE_LEN - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    idx_d        = idx_q;
    data_d       = data_q;
    // Requests latch at any time; a pulse while already pending is absorbed.
    pend_hora_d  = pend_hora_q  | camb_hora;
    pend_fecha_d = pend_fecha_q | camb_fecha;
    pend_crono_d = pend_crono_q | crono_req;
    sweep_due_d  = sweep_due_q;
    idle_cnt_d   = idle_cnt_q;
    tmo_d        = tmo_q;
    err_d        = err_q;
    cap_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!sweep_due_q) begin
          if (idle_cnt_q == RW'(REFRESH_CYCLES - 1)) sweep_due_d = 1'b1;
          else                                       idle_cnt_d  = idle_cnt_q + RW'(1);
        end
        if (pend_hora_q) begin
          op_d = OP_HORA;  data_d = hora_in;    pend_hora_d  = 1'b0;
          idx_d = '0;      state_d = ST_ISSUE;
        end else if (pend_fecha_q) begin
          op_d = OP_FECHA; data_d = fecha_in;   pend_fecha_d = 1'b0;
          idx_d = '0;      state_d = ST_ISSUE;
        end else if (pend_crono_q) begin
          op_d = OP_CRONO; data_d = crono_data; pend_crono_d = 1'b0;
          idx_d = '0;      state_d = ST_ISSUE;
        end else if (sweep_due_q) begin
          op_d = OP_READ;  sweep_due_d = 1'b0;  idle_cnt_d   = '0;
          idx_d = '0;      state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        tmo_d   = '0;
      end
      ST_WAIT: begin
        if (fin) begin
          state_d = ST_NEXT;
          cap_d   = (op_q == OP_READ);
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_NEXT: begin
        if (idx_q == last_idx) begin
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The ROM looks up the step about to be issued, so address/data are
  // registered on entry to ISSUE and then hold until the next ISSUE.
  rtc_addr_rom u_rom (
    .op_i   (op_d),
    .idx_i  (idx_d),
    .data_i (data_d),
    .addr_o (rom_addr),
    .data_o (rom_data)
  );

  always_comb begin
    addr_d = addr_q;
    dw_d   = dw_q;
    wr_d   = wr_q;
    cnt2_d = cnt2_q;
    if (state_d == ST_ISSUE) begin
      addr_d = rom_addr;
      wr_d   = (op_d != OP_READ);
      if (op_d == OP_READ) cnt2_d = idx_d;
      else                 dw_d   = rom_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= OP_READ;
      idx_q        <= '0;
      data_q       <= '0;
      pend_hora_q  <= 1'b0;
      pend_fecha_q <= 1'b0;
      pend_crono_q <= 1'b0;
      sweep_due_q  <= 1'b0;
      idle_cnt_q   <= '0;
      tmo_q        <= '0;
      err_q        <= 1'b0;
      cap_q        <= 1'b0;
      addr_q       <= '0;
      dw_q         <= '0;
      wr_q         <= 1'b0;
      cnt2_q       <= '0;
    end else begin
      op_q         <= op_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      pend_hora_q  <= pend_hora_d;
      pend_fecha_q <= pend_fecha_d;
      pend_crono_q <= pend_crono_d;
      sweep_due_q  <= sweep_due_d;
      idle_cnt_q   <= idle_cnt_d;
      tmo_q        <= tmo_d;
      err_q        <= err_d;
      cap_q        <= cap_d;
      addr_q       <= addr_d;
      dw_q         <= dw_d;
      wr_q         <= wr_d;
      cnt2_q       <= cnt2_d;
    end
  end

  assign inicio           = (state_q == ST_ISSUE);
  assign ocupado          = (state_q != ST_IDLE);
  assign IndicadorMaquina = wr_q;
  assign address          = addr_q;
  assign DATA_WRITE       = dw_q;
  assign contador2        = cnt2_q;
  assign captura          = cap_q;
  assign err_timeout      = err_q;

endmodule

// File: tb/tb_rtc_scheduler.sv
// Scoreboard bench for rtc_scheduler: stimulus pushes expected transactions
// (and captura pulses) into a queue; a monitor pops and compares each time
// the DUT asserts inicio or captura. A responder returns fin 3 cycles after
// each inicio unless disabled.
module tb_rtc_scheduler;

  typedef struct {
    logic       is_cap;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [3:0] idx;
  } exp_t;

`ifdef RTC_CRONO_EN
  localparam int unsigned NSW = 9;
`else
  localparam int unsigned NSW = 6;
`endif

  logic [7:0] sw_addr [9];

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        camb_hora = 1'b0, camb_fecha = 1'b0, camb_crono = 1'b0;
  logic [23:0] hora_in = '0, fecha_in = '0, crono_in = '0;
  logic        fin = 1'b0;
  logic        inicio, IndicadorMaquina, captura, ocupado, err_timeout;
  logic [7:0]  address, DATA_WRITE;
  logic [3:0]  contador2;

  exp_t        q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic        fin_en = 1'b1;
  logic [7:0]  last_addr = '0;
  logic        last_wr = 1'b0;

  rtc_scheduler #(.REFRESH_CYCLES(16), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .camb_hora(camb_hora), .camb_fecha(camb_fecha), .camb_crono(camb_crono),
    .hora_in(hora_in), .fecha_in(fecha_in), .crono_in(crono_in),
    .fin(fin), .inicio(inicio), .IndicadorMaquina(IndicadorMaquina),
    .address(address), .DATA_WRITE(DATA_WRITE), .contador2(contador2),
    .captura(captura), .ocupado(ocupado), .err_timeout(err_timeout)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_rd(input logic [7:0] a, input logic [3:0] i);
    exp_t e;
    e.is_cap = 1'b0; e.wr = 1'b0; e.addr = a; e.data = '0; e.idx = i;
    q.push_back(e);
    e.is_cap = 1'b1;
    q.push_back(e);
  endtask

  task automatic push_sweep();
    for (int unsigned i = 0; i < NSW; i++) push_rd(sw_addr[i], 4'(i));
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.is_cap = 1'b0; e.wr = 1'b1; e.addr = a; e.data = d; e.idx = '0;
    q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int unsigned n = 0;
    while ((q.size() != 0 || ocupado) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain_left"}, q.size(), 0);
  endtask

  task automatic wait_busy(input string name);
    int unsigned n = 0;
    while (!ocupado && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy"}, ocupado, 1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_inicio"},  inicio, 0);
    check({name, "_ind"},     IndicadorMaquina, 0);
    check({name, "_address"}, address, 8'h00);
    check({name, "_data"},    DATA_WRITE, 8'h00);
    check({name, "_cont2"},   contador2, 0);
    check({name, "_captura"}, captura, 0);
    check({name, "_ocupado"}, ocupado, 0);
    check({name, "_err"},     err_timeout, 0);
  endtask

  // fin responder: fin high in the third cycle after the inicio cycle.
  initial forever begin
    @(negedge clk);
    if (inicio && fin_en) begin
      repeat (3) @(posedge clk);
      #1 if (rst_n) fin = 1'b1;
      @(posedge clk);
      #1 fin = 1'b0;
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (inicio) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_inicio: got addr %0h, expected no transaction", address);
      end else begin
        e = q.pop_front();
        check("txn_is_start", {31'd0, e.is_cap}, 0);
        check("txn_wr", IndicadorMaquina, e.wr);
        check("txn_addr", address, e.addr);
        if (e.wr) check("txn_data", DATA_WRITE, e.data);
        last_addr = e.addr;
        last_wr   = e.wr;
      end
    end
    if (captura) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_captura: got index %0d, expected no pulse", contador2);
      end else begin
        e = q.pop_front();
        check("cap_is_capture", {31'd0, e.is_cap}, 1);
        check("cap_index", contador2, e.idx);
      end
    end
    if (fin && ocupado) begin
      check("hold_addr", address, last_addr);
      check("hold_wr", IndicadorMaquina, last_wr);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sw_addr = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

    // Reset and first automatic sweep.
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    push_sweep();
    wait_drain("sweep1");

    // hora write: inicio seen at the second edge after camb is sampled.
    push_wr(8'h21, 8'h56); push_wr(8'h22, 8'h34); push_wr(8'h23, 8'h12);
    push_sweep();
    hora_in = 24'h123456; camb_hora = 1'b1;
    @(negedge clk);
    camb_hora = 1'b0;
    check("hora_inicio_early", inicio, 0);
    @(negedge clk);
    check("hora_inicio_lat2", inicio, 1);
    hora_in = 24'hFFFFFF;
    wait_drain("hora");

    // Simultaneous requests; camb_fecha repeated while pending.
    push_wr(8'h21, 8'h0C); push_wr(8'h22, 8'h0B); push_wr(8'h23, 8'h0A);
    push_wr(8'h24, 8'h31); push_wr(8'h25, 8'h12); push_wr(8'h26, 8'h25);
`ifdef RTC_CRONO_EN
    push_wr(8'h41, 8'h30); push_wr(8'h42, 8'h45); push_wr(8'h43, 8'h59);
`endif
    push_sweep();
    hora_in = 24'h0A0B0C; fecha_in = 24'h251231; crono_in = 24'h594530;
    camb_hora = 1'b1; camb_fecha = 1'b1; camb_crono = 1'b1;
    @(negedge clk);
    camb_hora = 1'b0; camb_crono = 1'b0;
    @(negedge clk);
    camb_fecha = 1'b0;
    wait_drain("prio");

    // camb_fecha mid-sweep: sweep completes first.
    push_sweep();
    begin
      int unsigned n = 0;
      while (!(captura && contador2 == 4'd2) && n < 500) begin
        @(negedge clk);
        n++;
      end
      check("mid_sweep_reached", contador2, 2);
    end
    push_wr(8'h24, 8'h03); push_wr(8'h25, 8'h02); push_wr(8'h26, 8'h01);
    push_sweep();
    fecha_in = 24'h010203; camb_fecha = 1'b1;
    @(negedge clk);
    camb_fecha = 1'b0;
    wait_drain("nopreempt");

    // Timeout: fin withheld for the first hora byte.
    fin_en = 1'b0;
    push_wr(8'h21, 8'h77);
    hora_in = 24'h665577; camb_hora = 1'b1;
    @(negedge clk);
    camb_hora = 1'b0;
    wait_busy("tmo");
    repeat (255) @(negedge clk);
    check("tmo_still_wait", ocupado, 1);
    check("tmo_err_before", err_timeout, 0);
    @(negedge clk);
    check("tmo_idle", ocupado, 0);
    check("tmo_err_set", err_timeout, 1);
    fin_en = 1'b1;
    push_wr(8'h24, 8'h0D); push_wr(8'h25, 8'h0E); push_wr(8'h26, 8'h0F);
    push_sweep();
    fecha_in = 24'h0F0E0D; camb_fecha = 1'b1;
    @(negedge clk);
    camb_fecha = 1'b0;
    wait_drain("after_tmo");
    check("tmo_err_sticky", err_timeout, 1);

    // Reset in the middle of a write.
    push_wr(8'h21, 8'hCC);
    hora_in = 24'hAABBCC; camb_hora = 1'b1;
    @(negedge clk);
    camb_hora = 1'b0;
    wait_busy("midrst");
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    push_sweep();
    wait_drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rtc_scheduler.md
RTC_SCHEDULER -- requirements
Module: rtc_scheduler

Interface
REQ-001 SHALL have parameter REFRESH_CYCLES, default 100000, idle clocks between automatic read sweeps.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, max clocks to wait for `fin` per transaction.
REQ-003 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-004 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: camb_hora, camb_fecha, camb_crono  in  1 each  write-request pulses (time, date, chronometer).
REQ-006 SHALL have ports: hora_in, fecha_in, crono_in  in  24 each  BCD data {byte2,byte1,byte0}, sampled at grant.
REQ-007 SHALL have ports: fin  in  1  one-cycle transaction-done pulse from the RTC protocol engine.
REQ-008 SHALL have ports: inicio  out  1  one-cycle transaction start to the protocol engine.
REQ-009 SHALL have ports: IndicadorMaquina  out  1  1 = write, 0 = read, valid while inicio high and until fin.
REQ-010 SHALL have ports: address  out  8  RTC register address; DATA_WRITE  out  8  write byte.
REQ-011 SHALL have ports: contador2  out  4  read-sweep index; captura  out  1  pulse: read byte valid for index contador2.
REQ-012 SHALL have ports: ocupado  out  1  high outside IDLE; err_timeout  out  1  sticky timeout flag.

Function
REQ-013 SHALL implement states IDLE, ISSUE, WAIT, NEXT; inicio high only in ISSUE (exactly one cycle).
REQ-014 SHALL latch each camb_* high into its own pending flag; repeat pulses while pending are absorbed (no queueing).
REQ-015 SHALL grant in IDLE with fixed priority hora > fecha > crono > read sweep; sweep is never preempted once started.
REQ-016 SHALL, for a write grant, clear its pending flag, capture its 24-bit input and issue 3 writes byte0..byte2.
REQ-017 SHALL use write addresses: hora 0x21,0x22,0x23; fecha 0x24,0x25,0x26; crono 0x41,0x42,0x43.
REQ-018 SHALL issue read sweep in order 0x21..0x26 then 0x41..0x43, contador2 = 0..8.
REQ-019 SHALL pulse captura in the cycle after fin of each read, with contador2 still holding that index.
REQ-020 SHALL, from a camb_* sampling edge while in IDLE and nothing higher pending, assert inicio 2 cycles later.
REQ-021 SHALL advance in NEXT to the next byte/address or, after the last, return to IDLE (one cycle per NEXT).
REQ-022 SHALL count IDLE cycles; at REFRESH_CYCLES-1 set sweep_due; count restarts at 0 when a sweep starts.
REQ-023 SHALL, if fin and a new camb_* arrive in the same cycle, both take effect (pending set, transaction advances).
REQ-024 SHALL, if fin not seen within TIMEOUT_CYCLES in WAIT, set err_timeout, abandon the operation, return to IDLE.
REQ-025 SHALL ignore fin outside WAIT.
REQ-026 SHALL hold address/DATA_WRITE/IndicadorMaquina stable from ISSUE through the fin cycle.

Reset
REQ-027 SHALL on rst_n low asynchronously go to IDLE, clear pending flags, counters, sweep_due and err_timeout.
REQ-028 SHALL reset outputs: inicio 0, IndicadorMaquina 0, address 0x00, DATA_WRITE 0x00, contador2 0, captura 0, ocupado 0.
REQ-029 SHALL abandon any in-flight transaction on reset mid-operation with no further inicio until a new grant.

Configuration
REQ-030 SHALL, with RTC_CRONO_EN defined, include crono requester and addresses 0x41..0x43 in sweep (9 reads).
REQ-031 SHALL, without RTC_CRONO_EN, ignore camb_crono/crono_in and sweep 0x21..0x26 only (6 reads, contador2 0..5).

Structure
REQ-032 SHALL place state enum, address constants and sweep length in shared package rtc_pkg.
REQ-033 SHALL implement address/data byte selection in sub-module rtc_addr_rom (op kind + index -> address).

Verification
REQ-034 SHALL test: reset, then REFRESH_CYCLES=16, fin 3 cycles after each inicio -> reads 0x21..0x26,0x41..0x43, 9 captura pulses.
REQ-035 SHALL test: camb_hora with hora_in=0x123456 in IDLE -> inicio 2 cycles later, writes 0x21=0x56,0x22=0x34,0x23=0x12.
REQ-036 SHALL test: camb_crono, camb_fecha, camb_hora same cycle -> order hora, fecha, crono, then sweep.
REQ-037 SHALL test: camb_fecha during sweep -> sweep completes all indices, then 0x24..0x26 writes.
REQ-038 SHALL test: fin withheld -> err_timeout=1 after 255 WAIT cycles, IDLE, next request serviced normally.
REQ-039 SHALL test: rst_n low mid-write and without RTC_CRONO_EN -> outputs at reset values; sweep length 6, camb_crono ignored.
